// File: rtl/ps2_key_event_queue.sv
// Key event queue behind the PS/2 keyboard controller: edge-detects the event strobe,
// drops repeated codes inside a hold-off window, and buffers codes in a FWFT FIFO with IRQ.
module ps2_key_event_queue #(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 0
) (
    input  logic                     iCLK,
    input  logic                     iRST_n,
    input  logic [31:0]              iKeyCode,
    input  logic                     iKeyStrobe,
    input  logic                     iRead,
    input  logic                     iClrOvf,
    output logic [31:0]              oData,
    output logic                     oEmpty,
    output logic                     oFull,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOvf,
    output logic                     oIRQ
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic          strobe_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [7:0]    last_code_q, last_code_d;
    logic          last_vld_q, last_vld_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic [7:0]    code;
    logic          evt, drop, pass, empty, full, pop, push, ovf_set;

    // Upper key-code bits come from the controller but are never stored.
    logic          unused_code_hi;
    assign unused_code_hi = ^iKeyCode[31:8];

    always_comb begin
        code    = iKeyCode[7:0];
        evt     = iKeyStrobe & ~strobe_q;
        drop    = (HOLDOFF > 0) && last_vld_q && (hcnt_q != '0) && (code == last_code_q);
        pass    = evt && !drop;
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop     = iRead && !empty;
        // A pop frees a slot in the same cycle, so a full queue can still accept.
        push    = pass && (!full || pop);
        ovf_set = pass && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        hcnt_d      = hcnt_q;
        last_code_d = last_code_q;
        if (pass) begin
            hcnt_d      = HW'(HOLDOFF);
            last_code_d = code;
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - HW'(1);
        end
        last_vld_d = (pass || last_vld_q) && (hcnt_d != '0);

        ovf_d = ovf_set ? 1'b1 : (iClrOvf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            strobe_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hcnt_q      <= '0;
            last_code_q <= '0;
            last_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            strobe_q    <= iKeyStrobe;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hcnt_q      <= hcnt_d;
            last_code_q <= last_code_d;
            last_vld_q  <= last_vld_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage is not reset; the empty flag masks stale contents on oData.
    always_ff @(posedge iCLK) begin
        if (iRST_n && push) begin
            mem_q[wr_ptr_q] <= code;
        end
    end

    assign oEmpty = empty;
    assign oFull  = full;
    assign oCount = count_q;
    assign oOvf   = ovf_q;
    assign oIRQ   = !empty;
    assign oData  = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scenarios then random traffic, every cycle
// checked against a queue-based model of the event/filter/FIFO rules.
module tb_ps2_key_event_queue;
    localparam int DEPTH   = 8;
    localparam int HOLDOFF = 100;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, strobe, rd, clr;
    logic [31:0]   key;
    logic [31:0]   data;
    logic          empty, full, ovf, irq;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iKeyCode(key), .iKeyStrobe(strobe),
        .iRead(rd), .iClrOvf(clr), .oData(data), .oEmpty(empty), .oFull(full),
        .oCount(count), .oOvf(ovf), .oIRQ(irq)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;
    logic       m_last_vld = 1'b0;
    logic [7:0] m_last = 8'h00;
    longint     m_last_t = 0;
    longint     m_t = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: an event is a 0->1 strobe; a repeat of the last accepted code within
    // HOLDOFF cycles is ignored; the queue accepts while it has room after any pop.
    task automatic model_step(input logic s, input logic [7:0] c, input logic r,
                              input logic cl, input logic rs);
        logic evt, pass, pop, ovf_set;
        if (!rs) begin
            exp_q.delete();
            m_ovf = 0; m_prev = 0; m_last_vld = 0;
        end else begin
            evt  = s && !m_prev;
            m_prev = s;
            pass = evt && !(m_last_vld && c == m_last && (m_t - m_last_t) <= HOLDOFF);
            pop  = r && exp_q.size() > 0;
            ovf_set = 0;
            if (pass) begin
                m_last = c; m_last_t = m_t; m_last_vld = 1;
            end
            if (pop) void'(exp_q.pop_front());
            if (pass) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(c);
                else ovf_set = 1;
            end
            m_ovf = ovf_set ? 1'b1 : (cl ? 1'b0 : m_ovf);
        end
        m_t++;
    endtask

    task automatic check_all();
        logic [31:0] ed;
        ed = (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'd0;
        chk("data",  data,  ed);
        chk("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
        chk("full",  {31'd0, full},  {31'd0, exp_q.size() == DEPTH});
        chk("count", {{(32-CW){1'b0}}, count}, 32'(exp_q.size()));
        chk("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
        chk("irq",   {31'd0, irq},   {31'd0, exp_q.size() != 0});
    endtask

    task automatic cycle(input logic s, input logic [7:0] c, input logic r,
                         input logic cl, input logic rs);
        strobe = s; key = {24'($urandom), c}; rd = r; clr = cl; rst_n = rs;
        @(posedge clk);
        model_step(s, c, r, cl, rs);
        #1;
        check_all();
    endtask

    task automatic pulse_key(input logic [7:0] c);
        cycle(1, c, 0, 0, 1);
        cycle(0, c, 0, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 1);
    endtask

    task automatic pop_one();
        cycle(0, 8'h00, 1, 0, 1);
    endtask

    logic [7:0] pool [3] = '{8'h75, 8'h72, 8'h1C};

    initial begin
        strobe = 0; key = 0; rd = 0; clr = 0; rst_n = 0;
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        chk("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);

        // Basic FIFO order
        pulse_key(8'h75); pulse_key(8'h72); pulse_key(8'h75);
        chk("t1_count", {{(32-CW){1'b0}}, count}, 32'd3);
        chk("t1_data", data, 32'h00000075);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        pop_one(); chk("t1_pop1", data, 32'h00000072);
        pop_one(); chk("t1_pop2", data, 32'h00000075);
        pop_one(); chk("t1_pop3", data, 32'h00000000);
        chk("t1_empty", {31'd0, empty}, 32'd1);

        // Overflow on the 9th event, then clear
        for (int i = 0; i < 9; i++) pulse_key(8'h10 + 8'(i));
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        cycle(0, 8'h00, 0, 1, 1);
        chk("ovf_clr", {31'd0, ovf}, 32'd0);
        chk("ovf_head", data, 32'h00000010);

        // Full queue: push and pop together
        cycle(1, 8'h55, 1, 0, 1);
        chk("fullpp_count", {{(32-CW){1'b0}}, count}, 32'd8);
        chk("fullpp_head", data, 32'h00000011);
        cycle(0, 8'h55, 0, 0, 1);
        for (int i = 0; i < 8; i++) pop_one();
        chk("fullpp_drain", {31'd0, empty}, 32'd1);

        // Empty queue: push and pop together
        cycle(1, 8'h66, 1, 0, 1);
        chk("emptypp_count", {{(32-CW){1'b0}}, count}, 32'd1);
        cycle(0, 8'h66, 0, 0, 1);
        pop_one();

        // Hold-off filter
        idle(120);
        pulse_key(8'h75); idle(48);
        pulse_key(8'h75); idle(98);
        pulse_key(8'h75); idle(8);
        pulse_key(8'h72);
        chk("hold_count", {{(32-CW){1'b0}}, count}, 32'd3);
        chk("hold_e0", data, 32'h00000075);
        pop_one(); chk("hold_e1", data, 32'h00000075);
        pop_one(); chk("hold_e2", data, 32'h00000072);
        pop_one();
        for (int i = 0; i < 20; i++) cycle(1, 8'h33, 0, 0, 1);
        cycle(0, 8'h33, 0, 0, 1);
        chk("held_count", {{(32-CW){1'b0}}, count}, 32'd1);
        pop_one();

        // Reset mid-operation overrides push and pop
        for (int i = 0; i < 5; i++) pulse_key(8'h41 + 8'(i));
        cycle(1, 8'h46, 1, 0, 0);
        chk("mrst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        chk("mrst_data", data, 32'd0);
        cycle(0, 8'h00, 0, 0, 1);
        pulse_key(8'h5A);
        chk("mrst_push", data, 32'h0000005A);
        pop_one();

        // Pointer wrap
        for (int i = 0; i < 20; i++) begin
            pulse_key(8'h80 + 8'(i));
            chk("wrap_cnt", {31'd0, count <= CW'(1)}, 32'd1);
            pop_one();
        end

        // Random traffic: fill-biased, then drain-biased
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                cycle(1'($urandom_range(0, 1)),
                      pool[$urandom_range(0, 2)] ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00),
                      (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
                      $urandom_range(0, 15) == 0,
                      $urandom_range(0, 299) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
